dmem_access_ctrl: RTL and testbench

- Sequences data-memory accesses requested by the MEM stage: MemRead/MemWrite from the decode controls, carried down the pipeline.
- Sits between the EX/MEM pipeline register and a variable-latency data memory with a req/ack handshake.
- Holds the pipeline with a stall until the memory acknowledges, then returns load data.
- Provides a completed-access counter for performance debug.

---
 rtl/dmem_access_ctrl.sv | 111 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: holds the pipeline until the memory acks, then returns load data.
// Optional watchdog on the WAIT state is built when MEM_TIMEOUT_EN is defined.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [CNT_W-1:0]  acc_cnt_o,
    output logic              err_o
);

    // Handshake: mem_req_o stays high with stable we/addr/wdata until the
    // single-cycle mem_ack_i pulse; acks seen outside WAIT are ignored.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic       reqIn;

    assign reqIn   = MemRead_i | MemWrite_i;
    assign stall_o = !rst_i && (((state == IDLE) && reqIn) || (state == WAIT));

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

    logic [TW-1:0] waitCnt;
    logic          errQ;

    assign err_o = errQ;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
            acc_cnt_o   <= '0;
`ifdef MEM_TIMEOUT_EN
            waitCnt     <= '0;
            errQ        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (reqIn) begin
                        mem_addr_o  <= addr_i;
                        mem_wdata_o <= wdata_i;
                        mem_we_o    <= MemWrite_i;  // write wins when both are set
                        mem_req_o   <= 1'b1;
                        state       <= WAIT;
`ifdef MEM_TIMEOUT_EN
                        waitCnt     <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            rdata_o <= mem_rdata_i;
                        end
                        acc_cnt_o <= acc_cnt_o + CNT_W'(1);
                        state     <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (waitCnt == LAST_WAIT) begin
                        // Abandon the access; the pipeline still gets its DONE cycle.
                        mem_req_o <= 1'b0;
                        errQ      <= 1'b1;
                        if (!mem_we_o) begin
                            rdata_o <= '0;
                        end
                        state     <= DONE;
                    end else begin
                        waitCnt <= waitCnt + TW'(1);
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed accesses, expected DONE-cycle results queued by the
// driver and popped by a negedge monitor whenever a stall period ends.
module tb_dmem_access_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int TO = 8;
    // expected record: {stall length, rdata, acc count, err}
    localparam int EW = 8 + DW + CW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          MemRead, MemWrite, ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, memRdata;
    logic          stall, memReq, memWe, err;
    logic [DW-1:0] rdata, memWdata;
    logic [AW-1:0] memAddr;
    logic [CW-1:0] accCnt;

    logic [EW-1:0] exp_q[$];
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] modelRdata;
    logic [CW-1:0] modelCnt;
    logic          modelErr;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    dmem_access_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .CNT_W  (CW),
        .TIMEOUT(TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .MemRead_i  (MemRead),
        .MemWrite_i (MemWrite),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .stall_o    (stall),
        .rdata_o    (rdata),
        .mem_req_o  (memReq),
        .mem_we_o   (memWe),
        .mem_addr_o (memAddr),
        .mem_wdata_o(memWdata),
        .mem_ack_i  (ack),
        .mem_rdata_i(memRdata),
        .acc_cnt_o  (accCnt),
        .err_o      (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: a falling stall outside reset marks the DONE cycle
    int stallRun = 0;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            stallRun = 0;
        end else if (stall) begin
            stallRun++;
        end else if (stallRun > 0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got completion with empty queue at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("done_stall_len", 64'(stallRun), 64'(e[EW-1 -: 8]));
                chk("done_rdata", 64'(rdata), 64'(e[DW+CW:CW+1]));
                chk("done_acc_cnt", 64'(accCnt), 64'(e[CW:1]));
                chk("done_err", 64'(err), 64'(e[0]));
            end
            stallRun = 0;
        end
    end

    task automatic endReq();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    // Issue an access from IDLE; the memory acks in WAIT cycle d (d >= 1).
    // Returns in the DONE cycle, request inputs left as they were unless drop is set.
    task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int d, input logic [DW-1:0] rv,
                          input logic drop);
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        wdata    = wd;
        if (!wr) modelRdata = rv;
        modelCnt++;
        exp_q.push_back({8'(d + 1), modelRdata, modelCnt, modelErr});
        @(posedge clk); #1;
        if (drop) begin
            endReq();
            addr  = '0;
            wdata = '0;
        end
        for (int i = 1; i <= d; i++) begin
            chk("wait_req", 64'(memReq), 64'd1);
            chk("wait_we", 64'(memWe), 64'(wr));
            chk("wait_addr", 64'(memAddr), 64'(a));
            chk("wait_wdata", 64'(memWdata), 64'(wd));
            if (i == d) begin
                ack      = 1'b1;
                memRdata = rv;
            end
            @(posedge clk); #1;
        end
        ack      = 1'b0;
        memRdata = 32'h0BAD_0BAD;
        chk("done_req", 64'(memReq), 64'd0);
        chk("done_stall", 64'(stall), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; ack = 1'b0;
        addr = '0; wdata = '0; memRdata = '0;
        modelRdata = '0; modelCnt = '0; modelErr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        MemRead = 1'b1;
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_req", 64'(memReq), 64'd0);
        chk("reset_we", 64'(memWe), 64'd0);
        chk("reset_addr", 64'(memAddr), 64'd0);
        chk("reset_wdata", 64'(memWdata), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_cnt", 64'(accCnt), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        MemRead = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // read, ack in first WAIT cycle
        access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF, 1'b0);
        chk("read_done_addr", 64'(memAddr), 64'h40);
        endReq();
        @(posedge clk); #1;

        // write, 5-cycle ack delay, request inputs dropped during WAIT
        access(1'b0, 1'b1, 32'h80, 32'h12345678, 5, 32'h55555555, 1'b1);
        @(posedge clk); #1;
        chk("rdata_after_write", 64'(rdata), 64'hDEADBEEF);

        // back-to-back load then store, held through DONE
        access(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'hCAFEF00D, 1'b0);
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'h104, 32'hA5A5A5A5, 1, 32'h0, 1'b0);
        endReq();
        @(posedge clk); #1;
        chk("b2b_cnt", 64'(accCnt), 64'd4);

        // spurious ack in IDLE
        ack = 1'b1;
        memRdata = 32'h0000_0BAD;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("spur_stall", 64'(stall), 64'd0);
        chk("spur_req", 64'(memReq), 64'd0);
        chk("spur_cnt", 64'(accCnt), 64'd4);
        chk("spur_rdata", 64'(rdata), 64'hCAFEF00D);
        @(posedge clk); #1;
        chk("spur_stall_later", 64'(stall), 64'd0);

        // read and write together: the write wins
        access(1'b1, 1'b1, 32'h200, 32'h0F0F0F0F, 3, 32'h77777777, 1'b0);
        endReq();
        @(posedge clk); #1;

        // reset in the third WAIT cycle
        MemRead = 1'b1;
        addr = 32'h300;
        @(posedge clk); #1;
        endReq();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_req", 64'(memReq), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_req", 64'(memReq), 64'd0);
        chk("mid_reset_stall", 64'(stall), 64'd0);
        chk("mid_reset_cnt", 64'(accCnt), 64'd0);
        rst = 1'b0;
        modelCnt = '0;
        modelRdata = '0;
        @(posedge clk); #1;
        ack = 1'b1;
        memRdata = 32'h1111_2222;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("late_ack_cnt", 64'(accCnt), 64'd0);
        chk("late_ack_stall", 64'(stall), 64'd0);
        chk("late_ack_rdata", 64'(rdata), 64'd0);
        @(posedge clk); #1;

        // counting resumes after reset
        access(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'h13579BDF, 1'b0);
        endReq();
        @(posedge clk); #1;
        chk("post_reset_cnt", 64'(accCnt), 64'd1);

`ifdef MEM_TIMEOUT_EN
        // no ack: watchdog fires after TO WAIT cycles
        MemRead = 1'b1;
        addr = 32'h500;
        modelRdata = '0;
        modelErr = 1'b1;
        exp_q.push_back({8'(TO + 1), modelRdata, modelCnt, modelErr});
        @(posedge clk); #1;
        endReq();
        for (int i = 1; i <= TO; i++) begin
            chk("to_wait_req", 64'(memReq), 64'd1);
            @(posedge clk); #1;
        end
        chk("to_done_req", 64'(memReq), 64'd0);
        chk("to_done_err", 64'(err), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("to_err_sticky", 64'(err), 64'd1);
        chk("to_cnt", 64'(accCnt), 64'(modelCnt));
`else
        chk("err_tied_low", 64'(err), 64'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
